// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads 16-bit words from a 1-cycle synchronous
// instruction memory and holds each one until the core retires it. Optional FETCH_HALT_EN stops on a 0000 word.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [15:0]           imem_rdata,
  output logic [15:0]           instruction,
  output logic                  instr_valid,
  input  logic                  instr_done,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t state;

  // Memory request is a pure decode of state; the address always tracks the PC.
  assign imem_en   = (state == S_FETCH);
  assign imem_addr = pc;

`ifdef FETCH_HALT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instruction <= 16'h0000;
      instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          instruction <= imem_rdata;
`ifdef FETCH_HALT_EN
          // End-of-file word: park without issuing, PC stays on the 0000 word.
          if (imem_rdata == 16'h0000) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
`else
          instr_valid <= 1'b1;
          state       <= S_HOLD;
`endif
        end
        S_HOLD: begin
          if (instr_done) begin
            instr_valid <= 1'b0;
            pc          <= redirect ? redirect_pc : pc + PC_STEP;
            state       <= S_FETCH;
          end
        end
`ifdef FETCH_HALT_EN
        S_HALT:  state <= S_HALT;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a RESET_PC=0 instance for ordering, redirect, stray controls,
// end-of-file and async reset, plus a RESET_PC=FFFF instance for PC wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en, imem_en2;
  logic [15:0] imem_addr, imem_addr2;
  logic [15:0] imem_rdata = '0, imem_rdata2 = '0;
  logic [15:0] instruction, instruction2;
  logic        instr_valid, instr_valid2;
  logic        instr_done = 1'b0, instr_done2 = 1'b0;
  logic        redirect = 1'b0, redirect2 = 1'b0;
  logic [15:0] redirect_pc = '0, redirect_pc2 = '0;
  logic [15:0] pc, pc2;
  logic        halted, halted2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] w;
  } exp_t;
  exp_t sb[$];

  instr_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
    .instr_done(instr_done), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .halted(halted)
  );

  instr_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .instruction(instruction2), .instr_valid(instr_valid2),
    .instr_done(instr_done2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .pc(pc2), .halted(halted2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] memword(input logic [15:0] a);
    case (a)
      16'h0000: memword = 16'h4142;
      16'h0001: memword = 16'h4402;
      16'h0002: memword = 16'h0253;
      16'h0003: memword = 16'h0000;
      default:  memword = a ^ 16'hA5A5;
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= memword(imem_addr);
    if (imem_en2) imem_rdata2 <= memword(imem_addr2);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every rising instr_valid consumes one expected (pc, word).
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", instr_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", pc, e.a);
        chk("sb_instr", instruction, e.w);
      end
    end
    prev_v <= instr_valid;
  end

  task automatic expect_word(input logic [15:0] a);
    sb.push_back({a, memword(a)});
  endtask

  task automatic wait_valid(output int c);
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) chk("valid_timeout", instr_valid, 1'b1);
    c = cyc;
  endtask

  task automatic retire(input logic redir, input logic [15:0] tgt);
    instr_done  = 1'b1;
    redirect    = redir;
    redirect_pc = tgt;
    @(negedge clk);
    instr_done  = 1'b0;
    redirect    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, k, n;
    logic any_en;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_en", imem_en, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc_wrap", pc2, 16'hFFFF);

    // First fetch and in-order issue of words 0..2
    expect_word(16'h0000);
    rst = 1'b0;
    k = cyc;
    @(negedge clk);
    chk("first_en", imem_en, 1'b1);
    chk("first_addr", imem_addr, 16'h0000);
    @(negedge clk);
    chk("first_en_drop", imem_en, 1'b0);
    wait_valid(c);
    chk("first_latency", c - k, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) expect_word(16'(i + 1));
`ifndef FETCH_HALT_EN
      if (i == 2) expect_word(16'h0003);
`endif
      retire(1'b0, 16'h0000);
      n = cyc;
      if (i < 2) begin
        wait_valid(c);
        chk("bubble", c - n, 2);
      end
    end

`ifdef FETCH_HALT_EN
    repeat (2) @(negedge clk);
    chk("halt_flag", halted, 1'b1);
    chk("halt_valid", instr_valid, 1'b0);
    chk("halt_pc", pc, 16'h0003);
    chk("halt_instr", instruction, 16'h0000);
    any_en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_en |= imem_en;
    end
    chk("halt_no_fetch", any_en, 1'b0);
    chk("halt_still_invalid", instr_valid, 1'b0);
`else
    wait_valid(c);
    chk("eof_instr", instruction, 16'h0000);
    chk("eof_halted", halted, 1'b0);
    any_en = 1'b0;
`endif

    // Redirect at pc=1
    do_reset();
    expect_word(16'h0000);
    wait_valid(c);
    @(negedge clk);
    expect_word(16'h0001);
    retire(1'b0, 16'h0000);
    wait_valid(c);
    @(negedge clk);
    expect_word(16'h0010);
    retire(1'b1, 16'h0010);
    chk("redir_en", imem_en, 1'b1);
    chk("redir_addr", imem_addr, 16'h0010);
    chk("redir_pc", pc, 16'h0010);
    wait_valid(c);

    // Stray redirect without instr_done
    redirect    = 1'b1;
    redirect_pc = 16'h0030;
    repeat (5) @(negedge clk);
    chk("stray_pc", pc, 16'h0010);
    chk("stray_instr", instruction, memword(16'h0010));
    chk("stray_valid", instr_valid, 1'b1);
    chk("stray_en", imem_en, 1'b0);
    redirect = 1'b0;

    // instr_done pulsed while in WAIT is ignored
    expect_word(16'h0011);
    retire(1'b0, 16'h0000);
    @(negedge clk);
    instr_done  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    instr_done  = 1'b0;
    redirect    = 1'b0;
    wait_valid(c);
    @(negedge clk);
    chk("waitdone_valid", instr_valid, 1'b1);
    chk("waitdone_pc", pc, 16'h0011);
    chk("waitdone_en", imem_en, 1'b0);
    expect_word(16'h0012);
    retire(1'b0, 16'h0000);
    chk("advance_pc", pc, 16'h0012);
    wait_valid(c);

    // Async reset mid-HOLD at pc=5, with a pending instr_done
    do_reset();
    expect_word(16'h0000);
    wait_valid(c);
    @(negedge clk);
    expect_word(16'h0005);
    retire(1'b1, 16'h0005);
    wait_valid(c);
    @(negedge clk);
    chk("hold5_pc", pc, 16'h0005);
    #2;
    rst        = 1'b1;
    instr_done = 1'b1;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_addr", imem_addr, 16'h0000);
    chk("arst_instr", instruction, 16'h0000);
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_en", imem_en, 1'b0);
    chk("arst_halted", halted, 1'b0);
    @(negedge clk);
    instr_done = 1'b0;
    expect_word(16'h0000);
    rst = 1'b0;
    k = cyc;
    wait_valid(c);
    chk("restart_latency", c - k, 3);

    // PC wrap on the RESET_PC=FFFF instance
    n = 0;
    while (!instr_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_valid", instr_valid2, 1'b1);
    chk("wrap_pc0", pc2, 16'hFFFF);
    chk("wrap_instr0", instruction2, memword(16'hFFFF));
    instr_done2 = 1'b1;
    @(negedge clk);
    instr_done2 = 1'b0;
    chk("wrap_pc", pc2, 16'h0000);
    chk("wrap_addr", imem_addr2, 16'h0000);
    chk("wrap_en", imem_en2, 1'b1);
    repeat (2) @(negedge clk);
    chk("wrap_instr1", instruction2, 16'h4142);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
